// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bus: pipeline register/control taps in, stall/flush/forward controls out.
// The pipeline side uses the master modport, the hazard unit the slave modport.
interface hazard_unit_mc_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 16
);
  logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic              RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MulE, MemReqM, MemReadyM, ClearCount;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic              MulBusy;
  logic [PERF_W-1:0] StallCount;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulE, MemReqM, MemReadyM, ClearCount,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MulBusy, StallCount
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulE, MemReqM, MemReadyM, ClearCount,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MulBusy, StallCount
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use stall, branch flush,
// multi-cycle execute occupancy, data-memory wait freeze and a saturating stall counter.
module hazard_unit_mc #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_unit_mc_if.slave   hz
);

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;

  localparam logic              MUL_MC    = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MUL_LAT - 2);
  localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] count_q, count_d;

  logic memwait_c, mulstall_c, lwstall_c, branch_c, stall_fd_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Operand forwarding; M has priority over W, x0 never forwards
  always_comb begin
    fwd_a_c = 2'b00;
    if ((hz.rs1E != '0) && (hz.rs1E == hz.rdM) && hz.RegWriteM)      fwd_a_c = 2'b10;
    else if ((hz.rs1E != '0) && (hz.rs1E == hz.rdW) && hz.RegWriteW) fwd_a_c = 2'b01;
  end

  always_comb begin
    fwd_b_c = 2'b00;
    if ((hz.rs2E != '0) && (hz.rs2E == hz.rdM) && hz.RegWriteM)      fwd_b_c = 2'b10;
    else if ((hz.rs2E != '0) && (hz.rs2E == hz.rdW) && hz.RegWriteW) fwd_b_c = 2'b01;
  end

  // Hazard priority: memory wait freezes everything, then multi-cycle, then load-use/branch
  always_comb begin
    memwait_c  = hz.MemReqM & ~hz.MemReadyM;
    mulstall_c = ~memwait_c &
                 (((state_q == IDLE) & hz.MulE & MUL_MC) |
                  ((state_q == MUL_BUSY) & (cnt_q != '0)));
    lwstall_c  = ~memwait_c & ~mulstall_c & (hz.ResultSrcE == 2'b01) & (hz.rdE != '0) &
                 ((hz.rs1D == hz.rdE) | (hz.rs2D == hz.rdE));
    branch_c   = ~memwait_c & ~mulstall_c & hz.PCSrcE;
    stall_fd_c = memwait_c | mulstall_c | lwstall_c;
  end

  // Multi-cycle occupancy FSM; cnt counts remaining stall cycles after the first
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hz.MulE && MUL_MC && !memwait_c) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        if (!memwait_c) begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (hz.ClearCount)                          count_d = '0;
    else if (stall_fd_c && (count_q != PERF_MAX)) count_d = count_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign hz.ForwardAE  = fwd_a_c;
  assign hz.ForwardBE  = fwd_b_c;
  assign hz.StallF     = stall_fd_c;
  assign hz.StallD     = stall_fd_c;
  assign hz.StallE     = memwait_c | mulstall_c;
  assign hz.StallM     = memwait_c;
  assign hz.FlushW     = memwait_c;
  assign hz.FlushM     = mulstall_c;
  assign hz.FlushE     = lwstall_c | branch_c;
  assign hz.FlushD     = branch_c;
  assign hz.MulBusy    = (state_q == MUL_BUSY);
  assign hz.StallCount = count_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc: main instance (MUL_LAT=4, PERF_W=16),
// a PERF_W=4 instance for counter saturation and a MUL_LAT=1 instance.
module tb_hazard_unit_mc;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_unit_mc_if #(.REG_AW(5), .PERF_W(16)) hz ();
  hazard_unit_mc_if #(.REG_AW(5), .PERF_W(4))  hs ();
  hazard_unit_mc_if #(.REG_AW(5), .PERF_W(16)) h1 ();

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(4), .CNT_W(4), .PERF_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .hz(hz));
  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(4), .CNT_W(4), .PERF_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .hz(hs));
  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(1), .CNT_W(4), .PERF_W(16)) u_one (
    .clk(clk), .rst_n(rst_n), .hz(h1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0; hz.rdE = '0; hz.rdM = '0; hz.rdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
    hz.MulE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0; hz.ClearCount = 1'b0;
    hs.rs1D = '0; hs.rs2D = '0; hs.rs1E = '0; hs.rs2E = '0; hs.rdE = '0; hs.rdM = '0; hs.rdW = '0;
    hs.RegWriteM = 1'b0; hs.RegWriteW = 1'b0; hs.ResultSrcE = 2'b00; hs.PCSrcE = 1'b0;
    hs.MulE = 1'b0; hs.MemReqM = 1'b0; hs.MemReadyM = 1'b0; hs.ClearCount = 1'b0;
    h1.rs1D = '0; h1.rs2D = '0; h1.rs1E = '0; h1.rs2E = '0; h1.rdE = '0; h1.rdM = '0; h1.rdW = '0;
    h1.RegWriteM = 1'b0; h1.RegWriteW = 1'b0; h1.ResultSrcE = 2'b00; h1.PCSrcE = 1'b0;
    h1.MulE = 1'b0; h1.MemReqM = 1'b0; h1.MemReadyM = 1'b0; h1.ClearCount = 1'b0;
  endtask

  task automatic clear_count();
    hz.ClearCount = 1'b1;
    tick();
    hz.ClearCount = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    zero_inputs();
    #2;
    checks++; if (hz.StallCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", hz.StallCount); end
    checks++; if (hz.MulBusy !== 1'b0) begin errors++; $display("FAIL reset_mulbusy: got %b exp 0", hz.MulBusy); end
    checks++; if ({hz.StallF, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 0000000",
        {hz.StallF, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}); end
    checks++; if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b exp 0000", {hz.ForwardAE, hz.ForwardBE}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    hz.rs1E = 5'd5; hz.rs2E = 5'd5; hz.rdM = 5'd5; hz.RegWriteM = 1'b1; hz.rdW = 5'd5; hz.RegWriteW = 1'b1;
    #1;
    checks++; if (hz.ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_wins: got %b exp 10", hz.ForwardAE); end
    checks++; if (hz.ForwardBE !== 2'b10) begin errors++; $display("FAIL fwd_b_m: got %b exp 10", hz.ForwardBE); end
    hz.RegWriteM = 1'b0; #1;
    checks++; if (hz.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b exp 01", hz.ForwardAE); end
    hz.RegWriteM = 1'b1; hz.rs1E = 5'd0; hz.rdM = 5'd0; hz.rdW = 5'd0; #1;
    checks++; if (hz.ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b exp 00", hz.ForwardAE); end
    hz.rs2E = 5'd3; hz.rdW = 5'd3; hz.rdM = 5'd5; #1;
    checks++; if (hz.ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_w: got %b exp 01", hz.ForwardBE); end
    // forwarding stays live while the pipeline is frozen
    hz.MemReqM = 1'b1; hz.rs1E = 5'd5; #1;
    checks++; if ({hz.ForwardAE, hz.ForwardBE} !== 4'b1001) begin errors++; $display("FAIL fwd_stalled: got %b exp 1001", {hz.ForwardAE, hz.ForwardBE}); end
    zero_inputs(); #1;
  endtask

  task automatic test_loaduse();
    hz.ResultSrcE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7; #1;
    checks++; if ({hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushD} !== 5'b11100) begin
      errors++; $display("FAIL lw_rs2: got %b exp 11100", {hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushD}); end
    hz.rs2D = 5'd0; hz.rs1D = 5'd7; #1;
    checks++; if ({hz.StallF, hz.FlushE} !== 2'b11) begin errors++; $display("FAIL lw_rs1: got %b exp 11", {hz.StallF, hz.FlushE}); end
    hz.rdE = 5'd0; hz.rs1D = 5'd0; #1;
    checks++; if ({hz.StallF, hz.FlushE} !== 2'b00) begin errors++; $display("FAIL lw_x0: got %b exp 00", {hz.StallF, hz.FlushE}); end
    hz.ResultSrcE = 2'b00; hz.rdE = 5'd7; hz.rs1D = 5'd7; #1;
    checks++; if ({hz.StallF, hz.FlushE} !== 2'b00) begin errors++; $display("FAIL lw_notload: got %b exp 00", {hz.StallF, hz.FlushE}); end
    zero_inputs(); #1;
  endtask

  task automatic test_mul();
    logic exp_stall;
    logic exp_busy;
    clear_count();
    hz.MulE = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      exp_stall = (c < 4);
      exp_busy  = (c >= 2);
      checks++; if ({hz.StallF, hz.StallD, hz.StallE, hz.FlushM} !== {4{exp_stall}}) begin
        errors++; $display("FAIL mul_stall c%0d: got %b exp %b", c, {hz.StallF, hz.StallD, hz.StallE, hz.FlushM}, {4{exp_stall}}); end
      checks++; if (hz.MulBusy !== exp_busy) begin errors++; $display("FAIL mul_busy c%0d: got %b exp %b", c, hz.MulBusy, exp_busy); end
      tick();
    end
    hz.MulE = 1'b0; #1;
    checks++; if (hz.MulBusy !== 1'b0) begin errors++; $display("FAIL mul_done: got %b exp 0", hz.MulBusy); end
    checks++; if (hz.StallCount !== 16'd3) begin errors++; $display("FAIL mul_count: got %0d exp 3", hz.StallCount); end
  endtask

  task automatic test_back_to_back();
    logic exp_stall;
    logic exp_busy;
    clear_count();
    hz.MulE = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      #1;
      exp_stall = ((c % 4) != 0);
      exp_busy  = ((c % 4) != 1);
      checks++; if ({hz.StallF, hz.MulBusy} !== {exp_stall, exp_busy}) begin
        errors++; $display("FAIL b2b c%0d: got %b exp %b", c, {hz.StallF, hz.MulBusy}, {exp_stall, exp_busy}); end
      tick();
    end
    hz.MulE = 1'b0; #1;
    checks++; if (hz.StallCount !== 16'd6) begin errors++; $display("FAIL b2b_count: got %0d exp 6", hz.StallCount); end
  endtask

  task automatic test_memwait_mul();
    clear_count();
    hz.MulE = 1'b1;
    tick();
    tick();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++; if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushM, hz.MulBusy} !== 7'b1111101) begin
        errors++; $display("FAIL memwait c%0d: got %b exp 1111101", c,
          {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushM, hz.MulBusy}); end
      tick();
    end
    hz.MemReadyM = 1'b1; #1;
    checks++; if ({hz.StallF, hz.StallM, hz.FlushM, hz.FlushW} !== 4'b1010) begin
      errors++; $display("FAIL memrel_1: got %b exp 1010", {hz.StallF, hz.StallM, hz.FlushM, hz.FlushW}); end
    tick();
    checks++; if ({hz.StallF, hz.MulBusy} !== 2'b01) begin errors++; $display("FAIL memrel_2: got %b exp 01", {hz.StallF, hz.MulBusy}); end
    tick();
    hz.MulE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0; #1;
    checks++; if (hz.MulBusy !== 1'b0) begin errors++; $display("FAIL memrel_idle: got %b exp 0", hz.MulBusy); end
    checks++; if (hz.StallCount !== 16'd8) begin errors++; $display("FAIL memrel_count: got %0d exp 8", hz.StallCount); end
  endtask

  task automatic test_branch();
    hz.PCSrcE = 1'b1; hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0; #1;
    checks++; if ({hz.FlushD, hz.FlushE, hz.StallF} !== 3'b001) begin
      errors++; $display("FAIL br_memwait: got %b exp 001", {hz.FlushD, hz.FlushE, hz.StallF}); end
    tick();
    hz.MemReqM = 1'b0; #1;
    checks++; if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallE} !== 4'b1100) begin
      errors++; $display("FAIL br_taken: got %b exp 1100", {hz.FlushD, hz.FlushE, hz.StallF, hz.StallE}); end
    tick();
    zero_inputs(); #1;
  endtask

  task automatic test_mul_lat1();
    h1.MulE = 1'b1; #1;
    checks++; if ({h1.StallF, h1.FlushM} !== 2'b00) begin errors++; $display("FAIL lat1_stall: got %b exp 00", {h1.StallF, h1.FlushM}); end
    tick();
    checks++; if ({h1.MulBusy, h1.StallF} !== 2'b00) begin errors++; $display("FAIL lat1_busy: got %b exp 00", {h1.MulBusy, h1.StallF}); end
    h1.MulE = 1'b0;
  endtask

  task automatic test_saturate();
    hs.ClearCount = 1'b1;
    tick();
    hs.ClearCount = 1'b0;
    hs.MemReqM = 1'b1; hs.MemReadyM = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 14) begin
        checks++; if (hs.StallCount !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d exp 14", hs.StallCount); end
      end
    end
    checks++; if (hs.StallCount !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d exp 15", hs.StallCount); end
    hs.ClearCount = 1'b1; #1;
    checks++; if (hs.StallF !== 1'b1) begin errors++; $display("FAIL sat_stallf: got %b exp 1", hs.StallF); end
    tick();
    checks++; if (hs.StallCount !== 4'd0) begin errors++; $display("FAIL sat_clear: got %0d exp 0", hs.StallCount); end
    hs.ClearCount = 1'b0; hs.MemReqM = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_count();
    hz.MulE = 1'b1;
    tick();
    tick();
    checks++; if ({hz.MulBusy, hz.StallF} !== 2'b11) begin errors++; $display("FAIL rmid_busy: got %b exp 11", {hz.MulBusy, hz.StallF}); end
    checks++; if (hz.StallCount !== 16'd2) begin errors++; $display("FAIL rmid_count: got %0d exp 2", hz.StallCount); end
    hz.MulE = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({hz.MulBusy, hz.StallF, hz.FlushM} !== 3'b000) begin
      errors++; $display("FAIL rmid_async: got %b exp 000", {hz.MulBusy, hz.StallF, hz.FlushM}); end
    checks++; if (hz.StallCount !== 16'd0) begin errors++; $display("FAIL rmid_cnt0: got %0d exp 0", hz.StallCount); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if ({hz.MulBusy, hz.StallF, hz.StallE} !== 3'b000) begin
      errors++; $display("FAIL rmid_after: got %b exp 000", {hz.MulBusy, hz.StallF, hz.StallE}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_forward();
    test_loaduse();
    test_mul();
    test_back_to_back();
    test_memwait_mul();
    test_branch();
    test_mul_lat1();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
